// File: rtl/regfile_param_if.sv
// regfile_param_if: bus bundle for regfile_param.
//   master: drives read/write addresses, write data/strobe and clear request;
//           receives read data, busy and write_dropped.
//   slave : the register file side.
// Parameters DATA_WIDTH / ADDR_WIDTH must match the attached regfile_param.
interface regfile_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] read_address0;
  logic [DATA_WIDTH-1:0] read_data0;
  logic [ADDR_WIDTH-1:0] read_address1;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_enable;
  logic                  clear_req;
  logic                  busy;
  logic                  write_dropped;

  modport master (
    output read_address0, read_address1, write_address, write_data,
           write_enable, clear_req,
    input  read_data0, read_data1, busy, write_dropped
  );

  modport slave (
    input  read_address0, read_address1, write_address, write_data,
           write_enable, clear_req,
    output read_data0, read_data1, busy, write_dropped
  );
endinterface

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file, two combinational read ports,
// one clocked write port, optional hardwired-zero register 0 and a clear
// sequencer that zeroes one entry per cycle after reset or on clear_req.
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - synchronous active-low reset
//   bus    - regfile_param_if.slave: read_address0/1 -> read_data0/1,
//            write_address/write_data/write_enable, clear_req,
//            busy (sweep active), write_dropped (one-cycle reject pulse)
//
// Optional feature: define REGFILE_BYPASS_EN to forward write_data to a read
// port addressing the entry being written in the same cycle.
//
// state | meaning
// IDLE  | normal operation, reads/writes serviced
// CLEAR | sweeping clr_ptr over every entry, writes rejected, reads forced 0
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input logic             clk,
  input logic             rst_n,
  regfile_param_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [ADDR_WIDTH-1:0] clr_ptr_next;
  logic                  busy_int;
  logic                  dropped_q;
  logic                  wr_zero_addr;
  logic                  wr_accept;
  logic                  wr_reject;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd0;
  logic [DATA_WIDTH-1:0] rd1;

  // Writes to a hardwired-zero r0 vanish silently, never counted as rejected.
  assign wr_zero_addr = (ZERO_REG != 0) && (bus.write_address == '0);
  assign wr_accept    = (state == IDLE) && bus.write_enable && !bus.clear_req && !wr_zero_addr;
  assign wr_reject    = bus.write_enable && !wr_zero_addr && ((state == CLEAR) || bus.clear_req);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_ptr   <= '0;
      dropped_q <= 1'b0;
    end else begin
      state     <= state_next;
      clr_ptr   <= clr_ptr_next;
      dropped_q <= wr_reject;
    end
  end

  // Next-state logic
  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    case (state)
      IDLE: begin
        if (bus.clear_req) begin
          state_next   = CLEAR;
          clr_ptr_next = '0;
        end
      end
      CLEAR: begin
        // clr_ptr wraps to 0 naturally on the last entry
        clr_ptr_next = clr_ptr + 1'b1;
        if (clr_ptr == '1) state_next = IDLE;
      end
      default: begin
        state_next   = CLEAR;
        clr_ptr_next = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy_int = (state == CLEAR);
  end

  // Storage: the reset edge itself leaves the array untouched.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else if (wr_accept) begin
        mem[bus.write_address] <= bus.write_data;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_base;
  assign fwd_base = (state == IDLE) && bus.write_enable && !bus.clear_req;
`endif

  always_comb begin
    rd0 = mem[bus.read_address0];
`ifdef REGFILE_BYPASS_EN
    if (fwd_base && (bus.read_address0 == bus.write_address)) rd0 = bus.write_data;
`endif
    if (busy_int || ((ZERO_REG != 0) && (bus.read_address0 == '0))) rd0 = '0;
  end

  always_comb begin
    rd1 = mem[bus.read_address1];
`ifdef REGFILE_BYPASS_EN
    if (fwd_base && (bus.read_address1 == bus.write_address)) rd1 = bus.write_data;
`endif
    if (busy_int || ((ZERO_REG != 0) && (bus.read_address1 == '0))) rd1 = '0;
  end

  assign bus.read_data0    = rd0;
  assign bus.read_data1    = rd1;
  assign bus.busy          = busy_int;
  assign bus.write_dropped = dropped_q;

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: scoreboard bench for regfile_param (default parameters).
// Stimulus computes the expected per-cycle outputs from a behavioural model
// and queues them; a monitor on the falling edge pops and compares.
module tb_regfile_param;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int ZR    = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(ZR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int            phase;
    logic          busy;
    logic          dropped;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
  } exp_t;

  exp_t sb_q[$];
  int   passed = 0;
  int   total  = 0;
  int   phase  = 0;
  bit   armed  = 0;

  // Reference model: a sweep is just "cycles remaining"; the array is
  // zeroed as a whole when it ends (reads are forced 0 meanwhile anyway).
  logic [DW-1:0] mem_m [DEPTH];
  int            sweep_left = DEPTH;
  logic          drop_m = 1'b0;

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] ra);
    if (sweep_left > 0) return '0;
    if (ZR != 0 && ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.write_enable && !bus.clear_req && ra == bus.write_address) return bus.write_data;
`endif
    return mem_m[ra];
  endfunction

  task automatic model_edge(input logic r, input logic we, input logic cr,
                            input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    bit zero_wr;
    zero_wr = (ZR != 0) && (wa == 0);
    if (!r) begin
      sweep_left = DEPTH;
      drop_m = 1'b0;
    end else if (sweep_left > 0) begin
      drop_m = we && !zero_wr;
      sweep_left--;
      if (sweep_left == 0) for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    end else if (cr) begin
      drop_m = we && !zero_wr;
      sweep_left = DEPTH;
    end else begin
      drop_m = 1'b0;
      if (we && !zero_wr) mem_m[wa] = wd;
    end
  endtask

  // One clock cycle: drive, queue expectation, take the edge, update model.
  task automatic cycle(input logic r, input logic we, input logic cr,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    exp_t e;
    rst_n = r;
    bus.write_enable  = we;
    bus.clear_req     = cr;
    bus.write_address = wa;
    bus.write_data    = wd;
    bus.read_address0 = ra0;
    bus.read_address1 = ra1;
    if (armed) begin
      e.phase   = phase;
      e.busy    = (sweep_left > 0);
      e.dropped = drop_m;
      e.rd0     = model_read(ra0);
      e.rd1     = model_read(ra1);
      sb_q.push_back(e);
    end
    @(posedge clk);
    model_edge(r, we, cr, wa, wd);
    armed = 1;
    #1;
  endtask

  task automatic nop(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, ra0, ra1);
  endtask

  task automatic check(input string name, input int ph, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s phase %0d: got %h expected %h", name, ph, act, req);
  endtask

  // Monitor: outputs are combinational/registered, stable mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("busy",          e.phase, DW'(bus.busy),          DW'(e.busy));
        check("write_dropped", e.phase, DW'(bus.write_dropped), DW'(e.dropped));
        check("read_data0",    e.phase, bus.read_data0,         e.rd0);
        check("read_data1",    e.phase, bus.read_data1,         e.rd1);
      end
    end
  end

  initial begin
    // Phase 1: reset 3 cycles, sweep, then read every entry on both ports.
    phase = 1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0, AW'(i), AW'(i));
    for (int i = 0; i < DEPTH; i++) nop(AW'(i), AW'(DEPTH - 1 - i));
    for (int i = 0; i < DEPTH; i++) nop(AW'(i), AW'(DEPTH - 1 - i));

    // Phase 2: write r5, read r5 / r7 same cycle and next.
    phase = 2;
    cycle(1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd7);
    nop(5'd5, 5'd7);

    // Phase 3: write to hardwired r0.
    phase = 3;
    cycle(1'b1, 1'b1, 1'b0, 5'd0, 32'h12345678, 5'd0, 5'd0);
    nop(5'd0, 5'd0);
    nop(5'd0, 5'd5);

    // Phase 4: write colliding with clear_req.
    phase = 4;
    cycle(1'b1, 1'b1, 1'b0, 5'd3, 32'hCAFEF00D, 5'd3, 5'd5);
    cycle(1'b1, 1'b1, 1'b1, 5'd3, 32'h0BADBEEF, 5'd3, 5'd3);
    for (int i = 0; i < DEPTH + 2; i++) nop(5'd3, 5'd5);

    // Phase 5: fill, start a sweep, reset at sweep cycle 10.
    phase = 5;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 1'b0, AW'(i), $urandom, AW'(i), '0);
    cycle(1'b1, 1'b0, 1'b1, '0, '0, 5'd1, 5'd2);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, AW'(i), $urandom, AW'(i), AW'(i + 1));
    cycle(1'b0, 1'b1, 1'b0, 5'd4, 32'h44444444, 5'd4, 5'd4);
    for (int i = 0; i < DEPTH; i++) nop(AW'(i), AW'(i));
    for (int i = 0; i < DEPTH; i++) nop(AW'(i), AW'(DEPTH - 1 - i));

    // Phase 6: same-cycle read of the entry being written.
    phase = 6;
    cycle(1'b1, 1'b1, 1'b0, 5'd9, 32'h11111111, 5'd1, 5'd2);
    cycle(1'b1, 1'b1, 1'b0, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9);
    nop(5'd9, 5'd9);

    // Phase 7: randomized traffic with occasional clears and resets.
    phase = 7;
    for (int n = 0; n < 1500; n++) begin
      logic r, we, cr;
      logic [AW-1:0] wa, ra0, ra1;
      r   = ($urandom_range(0, 299) != 0);
      cr  = ($urandom_range(0, 79) == 0);
      we  = $urandom_range(0, 1) != 0;
      wa  = AW'($urandom_range(0, DEPTH - 1));
      ra0 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      cycle(r, we, cr, wa, $urandom, ra0, ra1);
    end
    nop('0, '0);

    repeat (3) @(negedge clk);
    total++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
